// File: rtl/dma_pkg.sv
// Shared definitions for the DMA engine: command encodings, FSM states and the address step.
package dma_pkg;

    typedef enum logic [1:0] {
        DMA_NOP   = 2'b00,
        DMA_LOAD  = 2'b01,
        DMA_STORE = 2'b10,
        DMA_RSVD  = 2'b11
    } dma_cmd_t;

    typedef enum logic [3:0] {
        IDLE,
        SETUP,
        L_REQ,
        L_WR,
        S_RD,
        S_CAP,
        S_REQ,
        STEP,
        DONE
    } dma_state_t;

    localparam int unsigned ADDR_STEP = 4;

endpackage

// File: rtl/dma_engine_if.sv
// Core command, SRAM and DRAM-adapter signals of the DMA engine; master is the engine side.
interface dma_engine_if #(
    parameter int unsigned SRAM_AW = 14,
    parameter int unsigned LEN_W   = 10,
    parameter int unsigned DRAM_AW = 32
);
    logic [1:0]         cmd;
    logic [31:0]        srcAddress;
    logic [31:0]        dstAddress;
    logic [LEN_W-1:0]   width;
    logic [31:0]        sramReadData;
    logic [SRAM_AW-1:0] sramAddress;
    logic [31:0]        sramWriteData;
    logic               sramWriteEnable;
    logic [DRAM_AW-1:0] dramAddress;
    logic [31:0]        dramWriteData;
    logic               dramReadEnable;
    logic               dramWriteEnable;
    logic [31:0]        dramReadData;
    logic               dramValid;
    logic               stall;
    logic               done;

    modport master (
        input  cmd, srcAddress, dstAddress, width, sramReadData, dramReadData, dramValid,
        output sramAddress, sramWriteData, sramWriteEnable, dramAddress, dramWriteData,
               dramReadEnable, dramWriteEnable, stall, done
    );

    modport slave (
        output cmd, srcAddress, dstAddress, width, sramReadData, dramReadData, dramValid,
        input  sramAddress, sramWriteData, sramWriteEnable, dramAddress, dramWriteData,
               dramReadEnable, dramWriteEnable, stall, done
    );

endinterface

// File: rtl/dma_addr_gen.sv
// Word count plus current DRAM byte address and SRAM word address for one DMA run.
module dma_addr_gen
    import dma_pkg::*;
#(
    parameter int unsigned SRAM_AW = 14,
    parameter int unsigned LEN_W   = 10,
    parameter int unsigned DRAM_AW = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [DRAM_AW-1:0] dram_base,
    input  logic [SRAM_AW-1:0] sram_base,
    input  logic [LEN_W-1:0]   count_init,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic [SRAM_AW-1:0] sram_word,
    output logic               last,
    output logic               zero
);
    localparam logic [DRAM_AW-1:0] DRAM_MASK = ~DRAM_AW'(3);

    logic [LEN_W-1:0] count_q;

    // SRAM side is kept as a word address: +1 word wraps exactly like +4 bytes mod 2^(SRAM_AW+2)
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q   <= '0;
            dram_addr <= '0;
            sram_word <= '0;
        end else if (load) begin
            count_q   <= count_init;
            dram_addr <= dram_base & DRAM_MASK;
            sram_word <= sram_base;
        end else if (step) begin
            count_q   <= count_q - LEN_W'(1);
            dram_addr <= dram_addr + DRAM_AW'(ADDR_STEP);
            sram_word <= sram_word + SRAM_AW'(ADDR_STEP / 4);
        end
    end

    assign last = (count_q == LEN_W'(1));
    assign zero = (count_q == '0);

endmodule

// File: rtl/dma_engine.sv
// DMA engine moving a contiguous run of 32-bit words between DRAM and core SRAM in either direction.
module dma_engine
    import dma_pkg::*;
#(
    parameter int unsigned SRAM_AW = 14,
    parameter int unsigned LEN_W   = 10,
    parameter int unsigned DRAM_AW = 32
) (
    input  logic        clk,
    input  logic        reset,
    dma_engine_if.master bus
);
    dma_state_t         state_q, state_d;
    logic               dir_store_q;
    logic [31:0]        data_q;
    logic               accept;
    logic               is_store_cmd;
    logic [31:0]        dram_sel;
    logic [31:0]        sram_sel;
    logic [DRAM_AW-1:0] dram_addr;
    logic [SRAM_AW-1:0] sram_word;
    logic               last;
    logic               zero;

    assign is_store_cmd = (bus.cmd == DMA_STORE);
    assign accept       = (state_q == IDLE) && ((bus.cmd == DMA_LOAD) || is_store_cmd);
    assign dram_sel     = is_store_cmd ? bus.dstAddress : bus.srcAddress;
    assign sram_sel     = is_store_cmd ? bus.srcAddress : bus.dstAddress;

    dma_addr_gen #(
        .SRAM_AW (SRAM_AW),
        .LEN_W   (LEN_W),
        .DRAM_AW (DRAM_AW)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .step       (state_q == STEP),
        .dram_base  (DRAM_AW'(dram_sel)),
        .sram_base  (SRAM_AW'(sram_sel >> 2)),
        .count_init (bus.width),
        .dram_addr  (dram_addr),
        .sram_word  (sram_word),
        .last       (last),
        .zero       (zero)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            dir_store_q <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept)
                dir_store_q <= is_store_cmd;
            if (state_q == L_REQ && bus.dramValid)
                data_q <= bus.dramReadData;
            else if (state_q == S_CAP)
                data_q <= bus.sramReadData;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = zero ? DONE : (dir_store_q ? S_RD : L_REQ);
            L_REQ:   if (bus.dramValid) state_d = L_WR;
            L_WR:    state_d = STEP;
            S_RD:    state_d = S_CAP;
            S_CAP:   state_d = S_REQ;
            S_REQ:   if (bus.dramValid) state_d = STEP;
            STEP:    state_d = last ? DONE : (dir_store_q ? S_RD : L_REQ);
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode from state only, so dramValid never reaches an output combinationally
    assign bus.sramAddress     = sram_word;
    assign bus.sramWriteData   = data_q;
    assign bus.sramWriteEnable = (state_q == L_WR);
    assign bus.dramAddress     = dram_addr;
    assign bus.dramWriteData   = data_q;
    assign bus.dramReadEnable  = (state_q == L_REQ);
    assign bus.dramWriteEnable = (state_q == S_REQ);
    assign bus.stall           = (state_q != IDLE);
    assign bus.done            = (state_q == DONE);

endmodule

// File: tb/tb_dma_engine.sv
// Scoreboard bench for dma_engine: SRAM/DRAM models, queue-based reference of expected traffic.
module tb_dma_engine;
    import dma_pkg::*;

    localparam int unsigned SRAM_AW = 14;
    localparam int unsigned LEN_W   = 10;
    localparam int unsigned DRAM_AW = 32;
    localparam int          LIMIT   = 4000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dma_engine_if #(.SRAM_AW(SRAM_AW), .LEN_W(LEN_W), .DRAM_AW(DRAM_AW)) bus ();

    dma_engine #(.SRAM_AW(SRAM_AW), .LEN_W(LEN_W), .DRAM_AW(DRAM_AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int fails  = 0;
    xfer_t exp_sram[$];
    xfer_t exp_dram[$];
    int exp_done = 0;

    logic [31:0] sram_mem [0:(1<<SRAM_AW)-1];
    logic               pre_we = 1'b0;
    logic [SRAM_AW-1:0] pre_addr = '0;
    logic [31:0]        pre_data = '0;
    int unsigned k_lat = 3;
    int unsigned dcnt = 0;

    // SRAM with one-cycle read latency; filled with a known pattern while reset is low
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < (1 << SRAM_AW); i++)
                sram_mem[i] <= 32'(i) * 32'h9E37_79B1 + 32'h1234_5678;
        end else begin
            if (pre_we) sram_mem[pre_addr] <= pre_data;
            if (bus.sramWriteEnable) sram_mem[bus.sramAddress] <= bus.sramWriteData;
        end
        bus.sramReadData <= sram_mem[bus.sramAddress];
    end

    // DRAM adapter: dramValid is high during the k-th cycle the enable has been high
    always @(posedge clk) begin
        if ((bus.dramReadEnable === 1'b1 || bus.dramWriteEnable === 1'b1) && bus.dramValid !== 1'b1) begin
            if (dcnt + 2 >= k_lat) begin
                bus.dramValid    <= 1'b1;
                bus.dramReadData <= bus.dramAddress ^ 32'hA5A5_A5A5;
                dcnt             <= 0;
            end else begin
                dcnt <= dcnt + 1;
            end
        end else begin
            bus.dramValid <= 1'b0;
            dcnt          <= 0;
        end
    end

    always @(negedge clk) begin
        xfer_t x;
        if (reset) begin
            if (bus.dramReadEnable || bus.dramWriteEnable) begin
                checks++;
                if (bus.dramReadEnable && bus.dramWriteEnable) begin
                    fails++;
                    $display("FAIL enable_overlap: rd=%b wr=%b, required at most one high", bus.dramReadEnable, bus.dramWriteEnable);
                end
            end
            if (bus.sramWriteEnable) begin
                checks++;
                if (exp_sram.size() == 0) begin
                    fails++;
                    $display("FAIL sram_write: got addr=%h data=%h, required no write", bus.sramAddress, bus.sramWriteData);
                end else begin
                    x = exp_sram.pop_front();
                    if (x.addr !== 32'(bus.sramAddress) || x.data !== bus.sramWriteData) begin
                        fails++;
                        $display("FAIL sram_write: got addr=%h data=%h, required addr=%h data=%h",
                                 bus.sramAddress, bus.sramWriteData, x.addr, x.data);
                    end
                end
            end
            if (bus.dramWriteEnable && bus.dramValid) begin
                checks++;
                if (exp_dram.size() == 0) begin
                    fails++;
                    $display("FAIL dram_write: got addr=%h data=%h, required no write", bus.dramAddress, bus.dramWriteData);
                end else begin
                    x = exp_dram.pop_front();
                    if (x.addr !== 32'(bus.dramAddress) || x.data !== bus.dramWriteData) begin
                        fails++;
                        $display("FAIL dram_write: got addr=%h data=%h, required addr=%h data=%h",
                                 bus.dramAddress, bus.dramWriteData, x.addr, x.data);
                    end
                end
            end
            if (bus.done) begin
                checks++;
                if (exp_done == 0 || exp_sram.size() != 0 || exp_dram.size() != 0) begin
                    fails++;
                    $display("FAIL done_pulse: got done with pending=%0d sram_left=%0d dram_left=%0d, required pending>0 and nothing left",
                             exp_done, exp_sram.size(), exp_dram.size());
                end else begin
                    exp_done--;
                end
            end
        end
    end

    task automatic push_expect(input logic [1:0] c, input logic [31:0] src, input logic [31:0] dst, input int w);
        xfer_t x;
        for (int i = 0; i < w; i++) begin
            if (c == DMA_LOAD) begin
                x.addr = ((dst >> 2) + 32'(i)) % (32'd1 << SRAM_AW);
                x.data = ((src & 32'hFFFF_FFFC) + 32'(4 * i)) ^ 32'hA5A5_A5A5;
                exp_sram.push_back(x);
            end else begin
                x.addr = (dst & 32'hFFFF_FFFC) + 32'(4 * i);
                x.data = sram_mem[((src >> 2) + 32'(i)) % (32'd1 << SRAM_AW)];
                exp_dram.push_back(x);
            end
        end
        exp_done++;
    endtask

    task automatic run_xfer(input logic [1:0] c, input logic [31:0] src, input logic [31:0] dst,
                            input int w, input int unsigned k, input bit noise);
        int cycles;
        int exp_cycles;
        bit saw_en;
        k_lat = k;
        push_expect(c, src, dst, w);
        @(negedge clk);
        bus.cmd = c; bus.srcAddress = src; bus.dstAddress = dst; bus.width = LEN_W'(w);
        @(negedge clk);
        bus.cmd = noise ? DMA_STORE : DMA_NOP;
        if (noise) begin
            bus.srcAddress = $urandom; bus.dstAddress = $urandom; bus.width = LEN_W'($urandom);
        end
        cycles = 0;
        saw_en = 1'b0;
        while (bus.stall === 1'b1 && cycles < LIMIT) begin
            cycles++;
            saw_en |= bus.dramReadEnable | bus.dramWriteEnable | bus.sramWriteEnable;
            @(negedge clk);
            if (noise) bus.cmd = cycles[0] ? DMA_RSVD : DMA_STORE;
        end
        bus.cmd = DMA_NOP;
        checks++;
        if (bus.stall !== 1'b0) begin
            fails++;
            $display("FAIL completion_timeout: got stall=%b after %0d cycles, required 0", bus.stall, cycles);
            $fatal(1, "engine stuck");
        end
        checks++;
        if (exp_done != 0 || exp_sram.size() != 0 || exp_dram.size() != 0) begin
            fails++;
            $display("FAIL transfer_complete: got pending_done=%0d sram_left=%0d dram_left=%0d, required all 0",
                     exp_done, exp_sram.size(), exp_dram.size());
            exp_sram.delete(); exp_dram.delete(); exp_done = 0;
        end
        if (c == DMA_LOAD || w == 0) begin
            exp_cycles = (w == 0) ? 2 : w * (int'(k) + 2) + 2;
            checks++;
            if (cycles != exp_cycles) begin
                fails++;
                $display("FAIL stall_cycles: got %0d, required %0d (cmd=%0d w=%0d k=%0d)", cycles, exp_cycles, c, w, k);
            end
        end
        if (w == 0) begin
            checks++;
            if (saw_en) begin
                fails++;
                $display("FAIL zero_length_traffic: got enable activity=1, required 0");
            end
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({bus.stall, bus.done, bus.dramReadEnable, bus.dramWriteEnable, bus.sramWriteEnable} !== 5'b0 ||
            bus.sramAddress !== '0 || bus.dramAddress !== '0 || bus.sramWriteData !== '0 || bus.dramWriteData !== '0) begin
            fails++;
            $display("FAIL %s: got stall=%b done=%b rd=%b wr=%b swe=%b sa=%h da=%h sd=%h dd=%h, required all 0",
                     name, bus.stall, bus.done, bus.dramReadEnable, bus.dramWriteEnable, bus.sramWriteEnable,
                     bus.sramAddress, bus.dramAddress, bus.sramWriteData, bus.dramWriteData);
        end
    endtask

    initial begin
        int rises;
        int cycles;
        logic prev;
        logic [1:0] c;
        bus.cmd = DMA_NOP; bus.srcAddress = '0; bus.dstAddress = '0; bus.width = '0;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset_state");
        reset = 1'b1;

        run_xfer(DMA_LOAD, 32'h0000_1000, 32'h0000_0040, 4, 3, 1'b0);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pre_we = 1'b1; pre_addr = SRAM_AW'(32'h20 + i); pre_data = 32'h11 * (i + 1);
        end
        @(negedge clk);
        pre_we = 1'b0;
        run_xfer(DMA_STORE, 32'h0000_0080, 32'h0000_2000, 3, 3, 1'b0);

        run_xfer(DMA_LOAD, 32'h0000_5000, 32'h0000_0200, 0, 3, 1'b0);
        run_xfer(DMA_STORE, 32'h0000_0300, 32'h0000_6000, 0, 2, 1'b0);
        run_xfer(DMA_LOAD, 32'h0000_7004, 32'h0000_0400, 3, 2, 1'b1);

        bus.cmd = DMA_RSVD;
        cycles = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.stall !== 1'b0) cycles++;
        end
        bus.cmd = DMA_NOP;
        checks++;
        if (cycles != 0) begin
            fails++;
            $display("FAIL reserved_cmd: got stall high for %0d cycles, required 0", cycles);
        end

        // Abort a 5-word LOAD once the second DRAM read request starts
        k_lat = 2;
        push_expect(DMA_LOAD, 32'h0000_3000, 32'h0000_0100, 5);
        @(negedge clk);
        bus.cmd = DMA_LOAD; bus.srcAddress = 32'h0000_3000; bus.dstAddress = 32'h0000_0100; bus.width = LEN_W'(5);
        @(negedge clk);
        bus.cmd = DMA_NOP;
        rises = 0; prev = 1'b0; cycles = 0;
        while (rises < 2 && cycles < 200) begin
            if (bus.dramReadEnable && !prev) rises++;
            prev = bus.dramReadEnable;
            if (rises < 2) begin
                @(negedge clk);
                cycles++;
            end
        end
        checks++;
        if (rises != 2) begin
            fails++;
            $display("FAIL abort_reach_word2: got %0d read requests, required 2", rises);
        end
        reset = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset_abort");
        reset = 1'b1;
        exp_sram.delete();
        exp_done = 0;
        repeat (6) @(negedge clk);
        check_outputs_zero("after_abort_idle");

        run_xfer(DMA_LOAD, 32'h0000_3000, 32'h0000_0100, 3, 3, 1'b0);
        run_xfer(DMA_LOAD, 32'h0000_8000, 32'h0000_FFF8, 4, 2, 1'b0);
        run_xfer(DMA_STORE, 32'h0000_FFFC, 32'hFFFF_FFF8, 3, 4, 1'b0);

        for (int n = 0; n < 20; n++) begin
            c = ($urandom_range(0, 1) == 0) ? DMA_LOAD : DMA_STORE;
            run_xfer(c, $urandom, $urandom, int'($urandom_range(0, 6)), $urandom_range(2, 5), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion, required $finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
